// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
// Glyph codes are 5 bits wide; segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int GLYPH_W = 5;

  typedef logic [GLYPH_W-1:0] glyph_t;
  typedef logic [6:0]         seg_t;

  // Codes 0..15 are the hex digits; the named letters follow.
  localparam glyph_t GLYPH_ZERO  = 5'd0;
  localparam glyph_t GLYPH_H     = 5'd16;
  localparam glyph_t GLYPH_L     = 5'd17;
  localparam glyph_t GLYPH_P     = 5'd18;
  localparam glyph_t GLYPH_U     = 5'd19;
  localparam glyph_t GLYPH_R     = 5'd20;
  localparam glyph_t GLYPH_N     = 5'd21;
  localparam glyph_t GLYPH_O     = 5'd22;
  localparam glyph_t GLYPH_DASH  = 5'd23;
  localparam glyph_t GLYPH_BLANK = 5'd31;

  // All segments dark.
  localparam seg_t SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational glyph code -> active-low seven-segment pattern.
// Codes 24..31 all render dark.
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [GLYPH_W-1:0] code_i,
  output logic [6:0]         seg_o
);

  // Pure lookup; the caller registers the result.
  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      5'd0:       seg_o = 7'h40;
      5'd1:       seg_o = 7'h79;
      5'd2:       seg_o = 7'h24;
      5'd3:       seg_o = 7'h30;
      5'd4:       seg_o = 7'h19;
      5'd5:       seg_o = 7'h12;
      5'd6:       seg_o = 7'h02;
      5'd7:       seg_o = 7'h78;
      5'd8:       seg_o = 7'h00;
      5'd9:       seg_o = 7'h10;
      5'd10:      seg_o = 7'h08;
      5'd11:      seg_o = 7'h03;
      5'd12:      seg_o = 7'h46;
      5'd13:      seg_o = 7'h21;
      5'd14:      seg_o = 7'h06;
      5'd15:      seg_o = 7'h0E;
      GLYPH_H:    seg_o = 7'h09;
      GLYPH_L:    seg_o = 7'h47;
      GLYPH_P:    seg_o = 7'h0C;
      GLYPH_U:    seg_o = 7'h41;
      GLYPH_R:    seg_o = 7'h2F;
      GLYPH_N:    seg_o = 7'h2B;
      GLYPH_O:    seg_o = 7'h23;
      GLYPH_DASH: seg_o = 7'h3F;
      default:    seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment driver with
// double-buffered glyph codes, leading-zero blanking and an anti-ghosting
// guard window at the start of every digit slot. All pins are active low.
// Optional feature macro: SEG_DIM_EN adds input bright[3:0], which shortens
// the lit part of each slot to ((bright+1)*(REFRESH_DIV-GUARD_CYC))>>4 cycles.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 2,
  parameter bit LZB         = 1'b1,
  parameter int DP_POS      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NDIG*GLYPH_W-1:0] glyph_in,
  input  logic [NDIG-1:0]         blank_mask,
  input  logic                    load,
`ifdef SEG_DIM_EN
  input  logic [3:0]              bright,
`endif
  output logic [NDIG-1:0]         an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CODE_W   = NDIG * GLYPH_W;
  localparam int ACT_SPAN = REFRESH_DIV - GUARD_CYC;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam bit DP_EN = (DP_POS >= 0) && (DP_POS < NDIG);

  // Scan position.
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             div_last;
  logic             wrap;

  // Shadow takes loads at any time; active is what is being displayed.
  logic [CODE_W-1:0] shadow_code_q, active_code_q;
  logic [NDIG-1:0]   shadow_mask_q, active_mask_q;

  // Registered pin drivers.
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            tick_q;

  // Per-digit decode of the active buffer.
  logic [GLYPH_W-1:0] code_a       [NDIG];
  logic               forced_a     [NDIG];
  logic               above_zero_a [NDIG];
  logic               blank_a      [NDIG];

  logic [GLYPH_W-1:0] cur_code;
  logic               cur_blank;
  logic [6:0]         rom_seg;
  logic               anode_on;
  logic               dp_here;

  // Next scan position: divider wraps each slot, index wraps each frame.
  always_comb begin
    div_last = (div_q == DIV_LAST);
    wrap     = div_last && (idx_q == IDX_LAST);
    div_d    = div_last ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (div_last) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
  end

  // Divider and scan index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // Double buffer: active only changes on the frame wrap, so a frame is never
  // drawn from two different loads. A load on the wrap cycle lands in shadow
  // while active picks up the previous shadow contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_code_q <= {NDIG{GLYPH_BLANK}};
      shadow_mask_q <= '0;
      active_code_q <= {NDIG{GLYPH_BLANK}};
      active_mask_q <= '0;
    end else begin
      if (load) begin
        shadow_code_q <= glyph_in;
        shadow_mask_q <= blank_mask;
      end
      if (wrap) begin
        active_code_q <= shadow_code_q;
        active_mask_q <= shadow_mask_q;
      end
    end
  end

  // Blanking per digit. above_zero_a[i] is set when every digit above i is a
  // zero or already dark, which makes a zero at i a leading zero.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    assign code_a[gi]   = active_code_q[gi*GLYPH_W +: GLYPH_W];
    assign forced_a[gi] = active_mask_q[gi] || (code_a[gi] == GLYPH_BLANK);

    if (gi == NDIG - 1) begin : g_top
      assign above_zero_a[gi] = 1'b1;
    end else begin : g_lower
      assign above_zero_a[gi] = above_zero_a[gi+1] &&
                                ((code_a[gi+1] == GLYPH_ZERO) || forced_a[gi+1]);
    end

    if ((gi == 0) || !LZB) begin : g_no_lz
      assign blank_a[gi] = forced_a[gi];
    end else begin : g_lz
      assign blank_a[gi] = forced_a[gi] ||
                           ((code_a[gi] == GLYPH_ZERO) && above_zero_a[gi]);
    end
  end

  assign cur_code  = code_a[idx_q];
  assign cur_blank = blank_a[idx_q];
  assign dp_here   = DP_EN && (int'(idx_q) == DP_POS);

  seg_glyph_rom u_glyph_rom (
    .code_i (cur_code),
    .seg_o  (rom_seg)
  );

`ifdef SEG_DIM_EN
  logic [3:0] bright_q;
  logic [3:0] bright_eff;
  int         on_len;

  // Brightness is held for the whole slot, captured when the slot starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      bright_q <= 4'hF;
    end else if (div_q == '0) begin
      bright_q <= bright;
    end
  end

  // Lit window: after the guard, for a brightness-scaled share of the slot.
  // At div_cnt==0 the live input is used so the sample point itself counts.
  always_comb begin
    bright_eff = (div_q == '0) ? bright : bright_q;
    on_len     = ((int'(bright_eff) + 1) * ACT_SPAN) >> 4;
    anode_on   = (int'(div_q) >= GUARD_CYC) &&
                 (int'(div_q) < GUARD_CYC + on_len);
  end
`else
  // Lit window: everything after the guard.
  always_comb begin
    anode_on = (int'(div_q) >= GUARD_CYC);
  end
`endif

  // Pin values for the current position; segments stay dark while no anode
  // is driven so nothing bleeds between digits.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (anode_on) begin
      an_d = ~(NDIG'(1) << idx_q);
      if (!cur_blank) begin
        seg_d = rom_seg;
      end
      dp_d = !dp_here;
    end
  end

  // Output registers, one cycle behind the scan position.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q   <= '1;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= wrap;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized scoreboard bench for seg_scan_driver.
// The driver computes each cycle's expected pins from a frame-level model
// (position within the frame, shadow/active digit arrays) and queues them;
// the monitor pops one entry per clock and compares it with the pins.
// Build with SEG_DIM_EN defined to exercise the brightness input.
module tb_seg_scan_driver;

  localparam int NDIG   = 4;
  localparam int RD     = 8;
  localparam int G      = 1;
  localparam bit LZB    = 1'b1;
  localparam int DP_POS = -1;
  localparam int FRAME  = NDIG * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [19:0] glyph_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  bright = 4'd15;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NDIG(NDIG), .REFRESH_DIV(RD), .GUARD_CYC(G), .LZB(LZB), .DP_POS(DP_POS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .glyph_in(glyph_in),
    .blank_mask(blank_mask),
    .load(load),
`ifdef SEG_DIM_EN
    .bright(bright),
`endif
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } out_t;

  out_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state.
  logic [6:0] glyph_tab [32];
  int         m_pos;
  int         m_brt;
  logic [4:0] sh_code [NDIG];
  logic [4:0] ac_code [NDIG];
  logic       sh_mask [NDIG];
  logic       ac_mask [NDIG];

  function automatic bit digit_dark(int i);
    bit dark;
    bit all_above;
    dark = ac_mask[i] || (ac_code[i] == 5'd31);
    if (LZB && i > 0 && ac_code[i] == 5'd0) begin
      all_above = 1'b1;
      for (int j = i + 1; j < NDIG; j++)
        if (!(ac_code[j] == 5'd0 || ac_mask[j] || ac_code[j] == 5'd31))
          all_above = 1'b0;
      if (all_above) dark = 1'b1;
    end
    return dark;
  endfunction

  // Predict the pins after the coming edge, then advance the model.
  task automatic model_step();
    out_t e;
    int   dv, ix, brt, on_len;
    bit   on;
    if (rst) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0;
      exp_q.push_back(e);
      m_pos = 0;
      m_brt = 15;
      for (int i = 0; i < NDIG; i++) begin
        sh_code[i] = 5'd31; ac_code[i] = 5'd31;
        sh_mask[i] = 1'b0;  ac_mask[i] = 1'b0;
      end
      return;
    end
    dv  = m_pos % RD;
    ix  = m_pos / RD;
    brt = (dv == 0) ? int'(bright) : m_brt;
`ifdef SEG_DIM_EN
    on_len = ((brt + 1) * (RD - G)) / 16;
`else
    on_len = RD - G;
`endif
    on    = (dv >= G) && (dv < G + on_len);
    e.an  = on ? ~(4'b0001 << ix) : 4'hF;
    e.seg = (on && !digit_dark(ix)) ? glyph_tab[ac_code[ix]] : 7'h7F;
    e.dp  = !(on && DP_POS >= 0 && ix == DP_POS);
    e.ft  = (m_pos == FRAME - 1);
    exp_q.push_back(e);
    if (dv == 0) m_brt = int'(bright);
    if (m_pos == FRAME - 1) begin
      ac_code = sh_code;
      ac_mask = sh_mask;
    end
    if (load) begin
      for (int i = 0; i < NDIG; i++) begin
        sh_code[i] = glyph_in[5*i +: 5];
        sh_mask[i] = blank_mask[i];
      end
    end
    m_pos = (m_pos + 1) % FRAME;
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_load(logic [19:0] codes, logic [3:0] mask);
    glyph_in   = codes;
    blank_mask = mask;
    load       = 1'b1;
    cycle();
    load       = 1'b0;
  endtask

  task automatic run_to_pos(int p);
    while (m_pos != p) cycle();
  endtask

  function automatic logic [4:0] rand_code();
    int r;
    if ($urandom_range(0, 2) == 0) return 5'd0;
    r = $urandom_range(0, 24);
    return (r == 24) ? 5'd31 : 5'(r);
  endfunction

  // Stimulus.
  initial begin
    logic [19:0] v;
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                  7'h09, 7'h47, 7'h0C, 7'h41, 7'h2F, 7'h2B, 7'h23, 7'h3F,
                  7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(FRAME);                                       // blank first frame
    do_load({5'd0, 5'd0, 5'd4, 5'd2}, 4'b0000);       // "  42"
    run(2 * FRAME);
    do_load({5'd1, 5'd0, 5'd0, 5'd7}, 4'b0000);       // "1007"
    run(2 * FRAME);
    run_to_pos(10);
    do_load({5'd0, 5'd0, 5'd1, 5'd5}, 4'b0000);       // A mid-frame
    run_to_pos(FRAME - 1);
    do_load({5'd16, 5'd0, 5'd0, 5'd3}, 4'b0100);      // B on the wrap cycle
    run(2 * FRAME + 3);
    run_to_pos(2 * RD + 5);                           // idx=2, div_cnt=5
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(FRAME + 2);
    do_load({5'd10, 5'd23, 5'd0, 5'd0}, 4'b0000);
    bright = 4'd7;
    run(2 * FRAME);
    bright = 4'd15;
    run(2 * FRAME);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NDIG; i++) v[5*i +: 5] = rand_code();
        glyph_in   = v;
        blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
        load       = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 40) == 0) bright = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 250) == 0);
      cycle();
    end
    rst  = 1'b0;
    load = 1'b0;
    run(2);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: one expectation per clock, plus frame-level invariants.
  int mon_cyc   = 0;
  int last_tick = -1;
  initial begin
    out_t e;
    out_t got;
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      if (exp_q.size() == 0) continue;
      e   = exp_q.pop_front();
      got = {an, seg, dp, frame_tick};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL pins cyc=%0d: got an=%h seg=%h dp=%b tick=%b, required an=%h seg=%h dp=%b tick=%b",
                 mon_cyc, got.an, got.seg, got.dp, got.ft, e.an, e.seg, e.dp, e.ft);
      end
      tests++;
      if ($countones(~an) > 1) begin
        fails++;
        $display("FAIL one_anode cyc=%0d: got an=%b, required at most one low", mon_cyc, an);
      end
      if (rst) begin
        last_tick = -1;
      end else if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          tests++;
          if (mon_cyc - last_tick != FRAME) begin
            fails++;
            $display("FAIL tick_period cyc=%0d: got %0d, required %0d",
                     mon_cyc, mon_cyc - last_tick, FRAME);
          end
        end
        last_tick = mon_cyc;
      end
    end
  end

endmodule
